// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
//
// Grants one requester at a time and launches its frame on the shared
// transmitter. After each frame ends (or times out) it enforces an idle gap
// before the next grant.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   req            : per-requester level request, held until its done pulse
//   req_msg        : packed payloads, requester i at [i*MSG_SIZE +: MSG_SIZE]
//   req_coded      : per-requester message type (1 = coded frame)
//   grant          : one-hot owner of the transmitter
//   done           : one-clock pulse to the owner when its frame completes
//   tx_start       : one-clock start pulse to the transmitter
//   tx_msg         : payload latched from the winner
//   tx_msg_select  : type bit latched from the winner
//   tx_busy        : transmitter status, high while shifting a frame
//   err            : one-clock pulse when tx_busy never rose after tx_start
module tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int MSG_SIZE      = 6,
  parameter int GAP_TICKS     = 27000000,
  parameter int TIMEOUT_TICKS = 270000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*MSG_SIZE-1:0] req_msg,
  input  logic [N_REQ-1:0]          req_coded,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      tx_start,
  output logic [MSG_SIZE-1:0]       tx_msg,
  output logic                      tx_msg_select,
  input  logic                      tx_busy,
  output logic                      err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // A zero or one tick gap/timeout still occupies one clock in its state.
  localparam int GAP_MAX = (GAP_TICKS > 1) ? GAP_TICKS : 1;
  localparam int TO_MAX  = (TIMEOUT_TICKS > 1) ? TIMEOUT_TICKS : 1;
  localparam int CNT_MAX = (GAP_MAX > TO_MAX) ? GAP_MAX : TO_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_MAX - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_MAX - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [N_REQ-1:0]      grant_q;
  logic [N_REQ-1:0]      done_q;
  logic                  tx_start_q;
  logic [MSG_SIZE-1:0]   tx_msg_q;
  logic                  tx_msg_select_q;
  logic                  err_q;

  // Arbitration result for the current request vector.
  logic                  any_req;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      ptr_d;
  logic [N_REQ-1:0]      grant_d;
  logic [MSG_SIZE-1:0]   win_msg;
  logic                  win_coded;
  int                    off;
  int                    best_off;

  // Round-robin: the requester with the smallest distance from ptr wins.
  // Each candidate's distance is (j - ptr) mod N_REQ, so ptr itself is 0.
  always_comb begin
    any_req   = |req;
    win_idx   = '0;
    grant_d   = '0;
    win_msg   = '0;
    win_coded = 1'b0;
    best_off  = N_REQ;
    off       = 0;
    for (int j = 0; j < N_REQ; j++) begin
      off = j - int'(ptr_q);
      if (off < 0) begin
        off = off + N_REQ;
      end
      if (req[j] && (off < best_off)) begin
        best_off   = off;
        win_idx    = PTR_W'(j);
        grant_d    = '0;
        grant_d[j] = 1'b1;
        win_msg    = req_msg[j*MSG_SIZE +: MSG_SIZE];
        win_coded  = req_coded[j];
      end
    end
    ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      ptr_q           <= '0;
      cnt_q           <= '0;
      grant_q         <= '0;
      done_q          <= '0;
      tx_start_q      <= 1'b0;
      tx_msg_q        <= '0;
      tx_msg_select_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one clock.
      tx_start_q <= 1'b0;
      done_q     <= '0;
      err_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            tx_msg_q        <= win_msg;
            tx_msg_select_q <= win_coded;
            grant_q         <= grant_d;
            ptr_q           <= ptr_d;
            state_q         <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          tx_start_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q == TO_LAST) begin
            // Transmitter never acknowledged: release the owner without done.
            err_q   <= 1'b1;
            grant_q <= '0;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (!tx_busy) begin
            done_q  <= grant_q;
            grant_q <= '0;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          grant_q <= '0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign tx_start      = tx_start_q;
  assign tx_msg        = tx_msg_q;
  assign tx_msg_select = tx_msg_select_q;
  assign err           = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - directed vector bench for tx_arbiter
module tb_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 6;
  localparam int GAP = 10;
  localparam int TO  = 50;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_msg = '0;
  logic [N-1:0]   req_coded = '0;
  logic           tx_busy = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           tx_start;
  logic [W-1:0]   tx_msg;
  logic           tx_msg_select;
  logic           err;

  // Second instance with a zero-length gap and a short timeout.
  logic [N-1:0]   z_req = '0;
  logic           z_busy = 1'b0;
  logic [N-1:0]   z_grant;
  logic [N-1:0]   z_done;
  logic           z_start;
  logic [W-1:0]   z_msg;
  logic           z_sel;
  logic           z_err;

  int tests = 0;
  int fails = 0;

  tx_arbiter #(.N_REQ(N), .MSG_SIZE(W), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_msg(req_msg), .req_coded(req_coded),
    .grant(grant), .done(done), .tx_start(tx_start), .tx_msg(tx_msg),
    .tx_msg_select(tx_msg_select), .tx_busy(tx_busy), .err(err)
  );

  tx_arbiter #(.N_REQ(N), .MSG_SIZE(W), .GAP_TICKS(0), .TIMEOUT_TICKS(4)) dut_z (
    .clk(clk), .rst_n(rst_n), .req(z_req), .req_msg(req_msg), .req_coded(req_coded),
    .grant(z_grant), .done(z_done), .tx_start(z_start), .tx_msg(z_msg),
    .tx_msg_select(z_sel), .tx_busy(z_busy), .err(z_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   req;
    logic [N*W-1:0] msg;
    logic [N-1:0]   coded;
    logic [7:0]     busy_dly;
    logic [7:0]     busy_len;
    logic [1:0]     exp_owner;
    logic [W-1:0]   exp_msg;
    logic           exp_sel;
  } vec_t;

  vec_t vecs [0:5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for tx_start; returns the number of clocks it took.
  task automatic wait_start(output int k);
    k = 0;
    while (tx_start !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int          k;
    logic [N-1:0] exp_oh;
    logic        bad;
    exp_oh    = 4'b0001 << v.exp_owner;
    req       = v.req;
    req_msg   = v.msg;
    req_coded = v.coded;
    wait_start(k);
    check($sformatf("v%0d latency", n), k, 2);
    check($sformatf("v%0d grant", n), grant, exp_oh);
    check($sformatf("v%0d tx_msg", n), tx_msg, v.exp_msg);
    check($sformatf("v%0d select", n), tx_msg_select, v.exp_sel);
    tick();
    check($sformatf("v%0d start_pulse", n), tx_start, 0);
    for (int i = 1; i < int'(v.busy_dly); i++) tick();
    tx_busy = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < int'(v.busy_len); i++) begin
      tick();
      if (done !== '0 || grant !== exp_oh) bad = 1'b1;
    end
    check($sformatf("v%0d hold_while_busy", n), bad, 0);
    tx_busy = 1'b0;
    tick();
    check($sformatf("v%0d done", n), done, exp_oh);
    check($sformatf("v%0d grant_drop", n), grant, 0);
    tick();
    check($sformatf("v%0d done_pulse", n), done, 0);
    req = '0;
    repeat (GAP + 2) tick();
  endtask

  initial begin
    int k;
    int last_cyc;
    int cyc;
    logic bad;

    //                req      msg3   msg2   msg1   msg0   coded  dly  len  own  msg    sel
    vecs[0] = '{4'b0001, {6'h00, 6'h00, 6'h00, 6'h2A}, 4'b0000, 8'd3, 8'd100, 2'd0, 6'h2A, 1'b0};
    vecs[1] = '{4'b0001, {6'h00, 6'h00, 6'h00, 6'h11}, 4'b0001, 8'd1, 8'd4,   2'd0, 6'h11, 1'b1};
    vecs[2] = '{4'b1010, {6'h3C, 6'h00, 6'h05, 6'h00}, 4'b0010, 8'd2, 8'd3,   2'd1, 6'h05, 1'b1};
    vecs[3] = '{4'b1010, {6'h3C, 6'h00, 6'h05, 6'h00}, 4'b0010, 8'd1, 8'd2,   2'd3, 6'h3C, 1'b0};
    vecs[4] = '{4'b0110, {6'h00, 6'h2F, 6'h1B, 6'h00}, 4'b0100, 8'd2, 8'd5,   2'd1, 6'h1B, 1'b0};
    vecs[5] = '{4'b1000, {6'h07, 6'h00, 6'h00, 6'h00}, 4'b1000, 8'd1, 8'd1,   2'd3, 6'h07, 1'b1};

    // Reset state
    #12;
    check("rst grant", grant, 0);
    check("rst done", done, 0);
    check("rst tx_start", tx_start, 0);
    check("rst tx_msg", tx_msg, 0);
    check("rst select", tx_msg_select, 0);
    check("rst err", err, 0);
    tick();
    rst_n = 1'b1;

    // Table: single frames with the round-robin pointer carried across them
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // All four requesting: served 0,1,2,3,0 with the gap between launches
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    req_msg = {6'h04, 6'h03, 6'h02, 6'h01};
    cyc = 0;
    last_cyc = -100;
    for (int i = 0; i < 5; i++) begin
      k = 0;
      bad = 1'b0;
      while (tx_start !== 1'b1 && k < 100) begin
        tick();
        k++;
        cyc++;
        if (grant !== '0 && grant !== 4'b0001 && grant !== 4'b0010 &&
            grant !== 4'b0100 && grant !== 4'b1000) bad = 1'b1;
        if (done !== '0 && err !== 1'b0) bad = 1'b1;
      end
      check($sformatf("rr%0d grant", i), grant, 4'b0001 << (i % 4));
      check($sformatf("rr%0d onehot", i), bad, 0);
      if (i > 0) check($sformatf("rr%0d spacing_ok", i), (cyc - last_cyc) >= GAP + 2, 1);
      last_cyc = cyc;
      tick(); cyc++;
      tx_busy = 1'b1;
      tick(); cyc++;
      tick(); cyc++;
      tx_busy = 1'b0;
    end
    req = '0;
    repeat (GAP + 6) tick();

    // Busy timeout
    req = 4'b0001;
    req_msg = {6'h00, 6'h00, 6'h00, 6'h09};
    wait_start(k);
    check("to latency", k, 2);
    k = 0;
    bad = 1'b0;
    while (err !== 1'b1 && k < 200) begin
      tick();
      k++;
      if (done !== '0) bad = 1'b1;
    end
    check("to err_clock", k, TO);
    check("to no_done", bad, 0);
    check("to grant_drop", grant, 0);
    k = 0;
    tick();
    k++;
    check("to err_pulse", err, 0);
    while (tx_start !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("to gap_then_start", k, GAP + 2);
    req = '0;
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    repeat (GAP + 4) tick();

    // Payload changed and request dropped after latching
    req = 4'b0001;
    req_msg = {6'h00, 6'h00, 6'h00, 6'h15};
    req_coded = 4'b0001;
    tick();
    check("lat grant", grant, 4'b0001);
    req_msg = {6'h00, 6'h00, 6'h00, 6'h3F};
    req_coded = 4'b0000;
    tick();
    check("lat start", tx_start, 1);
    check("lat msg_at_start", tx_msg, 6'h15);
    check("lat sel_at_start", tx_msg_select, 1);
    req = '0;
    tick();
    tx_busy = 1'b1;
    repeat (5) tick();
    check("lat msg_busy", tx_msg, 6'h15);
    tx_busy = 1'b0;
    tick();
    check("lat done", done, 4'b0001);
    check("lat msg_done", tx_msg, 6'h15);
    repeat (GAP + 2) tick();

    // Reset in the middle of a frame
    req = 4'b0100;
    req_msg = {6'h00, 6'h2D, 6'h00, 6'h00};
    req_coded = 4'b0100;
    wait_start(k);
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    check("mid grant", grant, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid async_grant", grant, 0);
    check("mid async_msg", tx_msg, 0);
    check("mid async_sel", tx_msg_select, 0);
    check("mid async_start", tx_start, 0);
    tx_busy = 1'b0;
    tick();
    tick();
    check("mid no_done", done, 0);
    check("mid no_err", err, 0);
    rst_n = 1'b1;
    wait_start(k);
    check("mid relaunch_latency", k, 2);
    check("mid relaunch_grant", grant, 4'b0100);
    check("mid relaunch_msg", tx_msg, 6'h2D);
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
    tick();
    check("mid done", done, 4'b0100);
    req = '0;
    repeat (GAP + 2) tick();

    // Zero-length gap: timeout 4, then a single gap clock before relaunch
    z_req = 4'b0001;
    k = 0;
    while (z_start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("z latency", k, 2);
    k = 0;
    while (z_err !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("z err_clock", k, 4);
    k = 0;
    while (z_start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("z relaunch", k, 3);
    z_req = '0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1);
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 SHALL have parameter MSG_SIZE, default 6, payload width per requester.
REQ-003 SHALL have parameter GAP_TICKS, default 27000000, idle clocks enforced between frames (1 s at 27 MHz).
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 270000, maximum clocks allowed for tx_busy to rise after tx_start.
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  N_REQ  per-requester level request, held until its done pulse.
REQ-008 SHALL have port req_msg  input  N_REQ*MSG_SIZE  payloads; requester i occupies bits [i*MSG_SIZE +: MSG_SIZE].
REQ-009 SHALL have port req_coded  input  N_REQ  per-requester message type, 1 = coded frame.
REQ-010 SHALL have port grant  output  N_REQ  one-hot, high while the corresponding requester owns the transmitter.
REQ-011 SHALL have port done  output  N_REQ  one-clock pulse to the owner when its frame completes.
REQ-012 SHALL have port tx_start  output  1  one-clock start pulse to the transmitter.
REQ-013 SHALL have port tx_msg  output  MSG_SIZE  payload latched from the winner, stable from tx_start until the frame ends.
REQ-014 SHALL have port tx_msg_select  output  1  latched req_coded bit of the winner.
REQ-015 SHALL have port tx_busy  input  1  transmitter status, high while a frame is being shifted out.
REQ-016 SHALL have port err  output  1  one-clock pulse on busy timeout.

Function
REQ-017 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
REQ-018 IDLE: when any req bit is high, SHALL select a winner round-robin, starting the search at index ptr, and go to LAUNCH on the next edge.
REQ-019 On leaving IDLE, SHALL latch winner payload and type into tx_msg/tx_msg_select, assert grant[winner], and set ptr to (winner+1) mod N_REQ.
REQ-020 LAUNCH: SHALL drive tx_start high for exactly one clock, clear the timeout counter, and go to WAIT_BUSY.
REQ-021 WAIT_BUSY: on tx_busy high, SHALL go to WAIT_DONE; when the counter reaches TIMEOUT_TICKS-1 with tx_busy low, SHALL pulse err, drop grant, pulse no done, and go to GAP.
REQ-022 WAIT_DONE: on tx_busy low, SHALL pulse done[winner] for one clock, drop grant the same clock, and go to GAP.
REQ-023 GAP: SHALL count GAP_TICKS clocks, then return to IDLE; requests SHALL NOT be granted during GAP.
REQ-024 IDLE to tx_start latency SHALL be exactly 2 clocks from the first edge sampling a req bit high.
REQ-025 Request dropped while granted SHALL NOT abort the frame; done still pulses.
REQ-026 req, req_msg, req_coded changes after latching SHALL NOT affect tx_msg/tx_msg_select.
REQ-027 All simultaneous requests SHALL each be served once before any requester is served twice.
REQ-028 ptr and counters SHALL wrap cleanly; GAP_TICKS=0 SHALL give a 1-clock GAP.
REQ-029 grant SHALL be zero or one-hot at all times; done and err SHALL never pulse in the same clock.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, ptr 0, counters 0, grant 0, done 0, tx_start 0, err 0, tx_msg 0, tx_msg_select 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no done or err pulse; first grant after release SHALL go to the lowest requesting index.

Verification
REQ-032 req=0001, msg0=6'h2A, coded0=0, busy high 3 clocks after start for 100 clocks -> tx_start 2 clocks after req, tx_msg=2A, select=0, done[0] one clock on busy fall.
REQ-033 req=1111 held, GAP_TICKS=10 -> grants in order 0,1,2,3,0; each consecutive tx_start separated by at least 10 idle clocks.
REQ-034 tx_busy never rises, TIMEOUT_TICKS=50 -> err pulse 50 clocks into WAIT_BUSY, no done, grant drops, GAP entered.
REQ-035 rst_n low during WAIT_DONE, req=0100 -> all outputs zero asynchronously; after release grant[2] with fresh tx_start.
REQ-036 req_msg changed from 6'h15 to 6'h3F one clock after grant -> tx_msg stays 15 until done.
